// File: rtl/ctrl.sv
// Pipeline control unit: turns the execute-stage jump/hold requests into
// PC redirect, flush and hold controls. A jump that arrives while the bus
// is stalled is parked and replayed once the bus releases.
//
// state    | meaning
// ---------+------------------------------------------------
// RUN      | previous cycle not held
// EX_HOLD  | previous cycle held by the execute stage
// BUS_HOLD | previous cycle held by the external bus
module ctrl #(
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] jump_addr_i,
  input  logic        jump_en_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_bus_i,
  output logic [31:0] jump_addr_o,
  output logic        jump_en_o,
  output logic        flush_o,
  output logic        hold_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] jump_cnt_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EX_HOLD  = 2'd1,
    BUS_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [31:0] hold_cnt;

  logic release_pend;
  logic direct_jump;
  logic capture;

  assign state_o = state;

  // Same-cycle redirect/flush/hold decode; a pending release outranks a new jump.
  always_comb begin
    release_pend = pend_valid & ~hold_flag_bus_i;
    direct_jump  = jump_en_i & ~hold_flag_bus_i & ~pend_valid;
    capture      = jump_en_i & hold_flag_bus_i & ~pend_valid;
    jump_en_o    = 1'b0;
    jump_addr_o  = 32'd0;
    flush_o      = 1'b0;
    hold_o       = 1'b0;
    if (!rst) begin
      if (release_pend) begin
        jump_en_o   = 1'b1;
        jump_addr_o = pend_addr;
      end else if (direct_jump) begin
        jump_en_o   = 1'b1;
        jump_addr_o = jump_addr_i;
      end
      // Flush on the raw request too, so wrong-path fetches die while the jump is parked.
      flush_o = jump_en_i | jump_en_o;
      hold_o  = hold_flag_bus_i | (hold_flag_ex_i & ~jump_en_i);
    end
  end

  // State register and pending-jump capture/release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
    end else begin
      if (hold_flag_bus_i)
        state <= BUS_HOLD;
      else if (hold_flag_ex_i && !jump_en_i)
        state <= EX_HOLD;
      else
        state <= RUN;

      if (release_pend) begin
        pend_valid <= 1'b0;
      end else if (capture) begin
        pend_valid <= 1'b1;
        pend_addr  <= jump_addr_i;
      end
    end
  end

  // Consecutive-hold watchdog with a sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= 32'd0;
      timeout_o <= 1'b0;
    end else if (hold_o) begin
      if (hold_cnt < HOLD_TIMEOUT)
        hold_cnt <= hold_cnt + 32'd1;
      if (hold_cnt == HOLD_TIMEOUT - 32'd1)
        timeout_o <= 1'b1;
    end else begin
      hold_cnt <= 32'd0;
    end
  end

  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= 32'd0;
      jump_cnt_o  <= 32'd0;
    end else begin
      if (hold_o && stall_cnt_o != 32'hFFFF_FFFF)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (jump_en_o && jump_cnt_o != 32'hFFFF_FFFF)
        jump_cnt_o <= jump_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_ctrl.sv
// Bench for ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_ctrl;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst, je, bus, ex;
  logic [31:0] ja;
  logic [31:0] jump_addr_o, stall_cnt_o, jump_cnt_o;
  logic        jump_en_o, flush_o, hold_o, timeout_o;
  logic [1:0]  state_o;

  ctrl #(.HOLD_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .jump_addr_i(ja), .jump_en_i(je),
    .hold_flag_ex_i(ex), .hold_flag_bus_i(bus),
    .jump_addr_o(jump_addr_o), .jump_en_o(jump_en_o),
    .flush_o(flush_o), .hold_o(hold_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .jump_cnt_o(jump_cnt_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_pend;
  logic [31:0] m_paddr;
  int          m_state;
  int          m_run;
  bit          m_to;
  logic [31:0] m_stall, m_jumps;
  // model's expectation for the current cycle
  bit          e_jen, e_flush, e_hold;
  logic [31:0] e_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic predict();
    e_jen = 0; e_addr = 0; e_flush = 0; e_hold = 0;
    if (!rst) begin
      if (m_pend && !bus) begin
        e_jen = 1; e_addr = m_paddr;
      end else if (!m_pend && !bus && je) begin
        e_jen = 1; e_addr = ja;
      end
      e_flush = je || e_jen;
      e_hold  = bus || (ex && !je);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_paddr = 0; m_state = 0; m_run = 0; m_to = 0;
    m_stall = 0; m_jumps = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, then compare everything.
  task automatic apply(input logic r, input logic j, input logic [31:0] a,
                       input logic b, input logic x);
    rst = r; je = j; ja = a; bus = b; ex = x;
    #1;
    predict();
    chk("jump_en_o",   {31'd0, jump_en_o}, {31'd0, e_jen});
    chk("jump_addr_o", jump_addr_o, e_addr);
    chk("flush_o",     {31'd0, flush_o}, {31'd0, e_flush});
    chk("hold_o",      {31'd0, hold_o}, {31'd0, e_hold});
    chk("state_o",     {30'd0, state_o}, m_state);
    chk("stall_cnt_o", stall_cnt_o, m_stall);
    chk("jump_cnt_o",  jump_cnt_o, m_jumps);
    chk("timeout_o",   {31'd0, timeout_o}, {31'd0, m_to});
  endtask

  // Advance through the rising edge and step the model with the same inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_pend && !bus) m_pend = 0;
      else if (!m_pend && je && bus) begin m_pend = 1; m_paddr = ja; end
      m_state = bus ? 2 : ((ex && !je) ? 1 : 0);
      if (e_hold) begin
        if (m_run < T) m_run++;
        if (m_run == T) m_to = 1;
        if (m_stall != 32'hFFFF_FFFF) m_stall++;
      end else begin
        m_run = 0;
      end
      if (e_jen && m_jumps != 32'hFFFF_FFFF) m_jumps++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0); tick();
  endtask

  initial begin
    rst = 1; je = 0; ja = 0; bus = 0; ex = 0;
    model_reset();
    @(negedge clk);

    // Reset, then idle five cycles.
    apply(1, 1, 32'hDEAD_BEEF, 1, 1);
    chk("rst_forces_jump_en", {31'd0, jump_en_o}, 0);
    chk("rst_forces_hold",    {31'd0, hold_o}, 0);
    tick();
    for (int i = 0; i < 5; i++) begin apply(0, 0, 0, 0, 0); tick(); end
    apply(0, 0, 0, 0, 0);
    chk("idle_state", {30'd0, state_o}, 0);
    chk("idle_stall", stall_cnt_o, 0);
    tick();

    // Direct redirect.
    do_reset();
    apply(0, 1, 32'h100, 0, 0);
    chk("direct_jen",   {31'd0, jump_en_o}, 1);
    chk("direct_addr",  jump_addr_o, 32'h100);
    chk("direct_flush", {31'd0, flush_o}, 1);
    chk("direct_hold",  {31'd0, hold_o}, 0);
    tick();
    apply(0, 0, 0, 0, 0);
    chk("direct_jcnt", jump_cnt_o, 1);
    tick();

    // Jump deferred under bus hold.
    do_reset();
    apply(0, 1, 32'h200, 1, 0);
    chk("defer_c1_flush", {31'd0, flush_o}, 1);
    chk("defer_c1_jen",   {31'd0, jump_en_o}, 0);
    chk("defer_c1_hold",  {31'd0, hold_o}, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 0, 1, 0);
      chk("defer_c23_hold",  {31'd0, hold_o}, 1);
      chk("defer_c23_flush", {31'd0, flush_o}, 0);
      chk("defer_c23_state", {30'd0, state_o}, 2);
      tick();
    end
    apply(0, 0, 0, 0, 0);
    chk("defer_c4_jen",   {31'd0, jump_en_o}, 1);
    chk("defer_c4_addr",  jump_addr_o, 32'h200);
    chk("defer_c4_flush", {31'd0, flush_o}, 1);
    tick();
    apply(0, 0, 0, 0, 0);
    chk("defer_c5_state", {30'd0, state_o}, 0);
    chk("defer_c5_stall", stall_cnt_o, 3);
    tick();

    // Execute hold for four cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 1);
      chk("exhold_hold", {31'd0, hold_o}, 1);
      tick();
    end
    apply(0, 0, 0, 0, 0);
    chk("exhold_state_last", {30'd0, state_o}, 1);
    chk("exhold_stall", stall_cnt_o, 4);
    tick();
    apply(0, 0, 0, 0, 0);
    chk("exhold_back_run", {30'd0, state_o}, 0);
    tick();
    // Same, with a jump on the second cycle.
    do_reset();
    apply(0, 0, 0, 0, 1); tick();
    apply(0, 1, 32'h444, 0, 1);
    chk("exjump_hold", {31'd0, hold_o}, 0);
    chk("exjump_jen",  {31'd0, jump_en_o}, 1);
    chk("exjump_addr", jump_addr_o, 32'h444);
    tick();
    apply(0, 0, 0, 0, 1);
    chk("exjump_state_run", {30'd0, state_o}, 0);
    tick();
    apply(0, 0, 0, 0, 1); tick();
    apply(0, 0, 0, 0, 0);
    chk("exjump_stall", stall_cnt_o, 3);
    tick();

    // Timeout boundary: 7 holds do not trip it, 8 do.
    do_reset();
    for (int i = 0; i < 7; i++) begin apply(0, 0, 0, 1, 0); tick(); end
    apply(0, 0, 0, 0, 0);
    chk("timeout_7", {31'd0, timeout_o}, 0);
    tick();
    for (int i = 0; i < 8; i++) begin apply(0, 0, 0, 1, 0); tick(); end
    apply(0, 0, 0, 0, 0);
    chk("timeout_8", {31'd0, timeout_o}, 1);
    tick();
    apply(0, 0, 0, 0, 0);
    chk("timeout_sticky", {31'd0, timeout_o}, 1);
    tick();
    do_reset();
    apply(0, 0, 0, 0, 0);
    chk("timeout_cleared", {31'd0, timeout_o}, 0);
    tick();

    // Reset discards a parked jump.
    do_reset();
    apply(0, 1, 32'h300, 1, 0); tick();
    apply(0, 0, 0, 1, 0); tick();
    apply(1, 0, 0, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0);
      chk("discard_jen", {31'd0, jump_en_o}, 0);
      tick();
    end
    apply(0, 0, 0, 0, 0);
    chk("discard_jcnt",  jump_cnt_o, 0);
    chk("discard_stall", stall_cnt_o, 0);
    tick();

    // Randomized run with bursty stall inputs.
    begin
      logic rb, rx;
      rb = 0; rx = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 3) == 0) rb = ~rb;
        if ($urandom_range(0, 3) == 0) rx = ~rx;
        apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
              $urandom, rb, rx);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl.md
CTRL -- requirements
Module: ctrl
Pipeline control unit. Consumes the execute-stage jump/hold interface; drives PC redirect, flush and hold to pc_reg, if_id and id_ex.

Interface
REQ-001 Parameter: HOLD_TIMEOUT, default 1024, consecutive-hold-cycle limit that sets timeout_o.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock, rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 jump_addr_i  in  32  branch/jump target from execute stage.
REQ-006 jump_en_i  in  1  execute-stage redirect request.
REQ-007 hold_flag_ex_i  in  1  execute-stage multi-cycle stall request, level.
REQ-008 hold_flag_bus_i  in  1  external bus stall request, level.
REQ-009 jump_addr_o  out  32  redirect target to pc_reg; 0 when jump_en_o=0.
REQ-010 jump_en_o  out  1  PC load strobe to pc_reg.
REQ-011 flush_o  out  1  clears if_id and id_ex to NOP; overrides hold in those registers.
REQ-012 hold_o  out  1  freezes pc_reg, if_id, id_ex.
REQ-013 state_o  out  2  current state: RUN=0, EX_HOLD=1, BUS_HOLD=2.
REQ-014 stall_cnt_o  out  32  total cycles with hold_o=1.
REQ-015 jump_cnt_o  out  32  total cycles with jump_en_o=1.
REQ-016 timeout_o  out  1  sticky hold-timeout error flag.

Function
REQ-017 jump_en_o, jump_addr_o, flush_o and hold_o SHALL be combinational in the same cycle as their inputs; all other outputs SHALL be registered.
REQ-018 Per-cycle priority SHALL be: rst > pending release > jump_en_i > hold_flag_bus_i > hold_flag_ex_i.
REQ-019 hold_o SHALL be: hold_flag_bus_i OR (hold_flag_ex_i AND NOT jump_en_i).
REQ-020 Pending jump register: pend_valid (1 bit) and pend_addr (32 bit).
REQ-021 Capture: if jump_en_i=1, hold_flag_bus_i=1 and pend_valid=0, the block SHALL set pend_valid and load pend_addr=jump_addr_i at the clock edge.
REQ-022 If pend_valid=1, a further jump_en_i during bus hold SHALL be ignored.
REQ-023 Direct redirect: jump_en_i=1, hold_flag_bus_i=0, pend_valid=0 -> jump_en_o=1, jump_addr_o=jump_addr_i.
REQ-024 Pending release: pend_valid=1, hold_flag_bus_i=0 -> jump_en_o=1, jump_addr_o=pend_addr, and pend_valid clears at the edge.
REQ-025 During pending release, jump_en_i SHALL be ignored.
REQ-026 flush_o SHALL be jump_en_i OR jump_en_o, so wrong-path instructions are killed even while the redirect is deferred.
REQ-027 Next state: hold_flag_bus_i=1 -> BUS_HOLD.
REQ-028 Next state otherwise: hold_flag_ex_i=1 AND jump_en_i=0 -> EX_HOLD.
REQ-029 Next state otherwise -> RUN.
REQ-030 The transition rules SHALL apply identically from every state.
REQ-031 hold_cnt (internal) SHALL increment each cycle hold_o=1, clear when hold_o=0, and saturate at HOLD_TIMEOUT.
REQ-032 timeout_o SHALL set at the edge where hold_cnt reaches HOLD_TIMEOUT (the HOLD_TIMEOUT-th consecutive hold cycle) and clear only on rst.
REQ-033 stall_cnt_o and jump_cnt_o SHALL each increment by 1 per qualifying cycle and saturate at 32'hFFFF_FFFF, with no wrap.
REQ-034 Simultaneous jump_en_i=1 and hold_flag_ex_i=1 with bus=0: jump taken, hold_o=0, next state RUN.

Reset
REQ-035 While rst=1: jump_en_o, flush_o and hold_o SHALL be 0, and jump_addr_o SHALL be 0, regardless of inputs.
REQ-036 At a rst edge: state RUN, pend_valid=0, pend_addr=0, hold_cnt=0, stall_cnt_o=0, jump_cnt_o=0, timeout_o=0.
REQ-037 Reset asserted mid-pending SHALL discard the pending jump; no redirect occurs after reset release.

Verification
REQ-038 Reset, then all inputs 0 for 5 cycles -> all outputs 0, state_o=0.
REQ-039 RUN, jump_en_i=1, jump_addr_i=0x100 for 1 cycle -> same cycle jump_en_o=1, jump_addr_o=0x100, flush_o=1, hold_o=0; next cycle jump_cnt_o=1.
REQ-040 hold_flag_bus_i=1 cycles 1-3, jump_en_i=1 with addr 0x200 in cycle 1 only:
- cycle 1: flush_o=1, jump_en_o=0, hold_o=1.
- cycles 2-3: hold_o=1, flush_o=0, state_o=2.
- cycle 4: jump_en_o=1, jump_addr_o=0x200, flush_o=1.
- cycle 5: state_o=0, stall_cnt_o=3.
REQ-041 hold_flag_ex_i=1 for 4 cycles -> hold_o=1 for 4 cycles, state_o=1 during the hold, then RUN; stall_cnt_o=4. Repeat with jump_en_i=1 on the 2nd cycle -> hold_o=0 that cycle, redirect taken.
REQ-042 HOLD_TIMEOUT=8, hold_flag_bus_i=1 for 7 cycles -> timeout_o=0; for 8 cycles -> timeout_o=1 after the 8th edge, still 1 after bus release, cleared by rst.
REQ-043 Capture pending 0x300 under bus hold, assert rst for 1 cycle, then release bus -> jump_en_o never asserts, counters 0.
